// File: rtl/rv_wb_pkg.sv
// Shared types for the register-file writeback path.
//   DATA_W / ADDR_W : register data width and register index width
//   reg_addr_t      : register index
//   word_t          : register data word
//   wb_req_t        : one pending register write {rd, data}
package rv_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests (load returns waiting for the
// register file write port).
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_req  : enqueue push_req when push=1 (caller guarantees !full)
//   pop             : dequeue the head when pop=1 (caller guarantees !empty)
//   head            : oldest entry, valid while !empty
//   full, empty     : occupancy flags from the registered count
//   ent_valid/ent_rd: per-slot occupancy and destination taps for hazard checks
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_req_t               push_req,
    input  logic                  pop,
    output wb_req_t               head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      ent_valid,
    output reg_addr_t [DEPTH-1:0] ent_rd
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] offset;

            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (push && (wr_ptr_q == PW'(gi))) begin
                    mem_d[gi] = push_req;
                end
            end

            // Storage carries no reset; occupancy is tracked by the pointers.
            always_ff @(posedge clk) begin
                mem_q[gi] <= mem_d[gi];
            end

            // A slot is live when its distance from the head is below the count.
            assign offset        = PW'(gi) - rd_ptr_q;
            assign ent_valid[gi] = ({1'b0, offset} < count_q);
            assign ent_rd[gi]    = mem_q[gi].rd;
        end
    endgenerate

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Writer-side controller for the register file write port.
// Merges single-cycle ALU results with buffered load returns into a single
// registered write, ALU first, but after STARVE_MAX consecutive ALU wins with
// loads waiting the ALU is held off for a cycle so the oldest load drains.
// Also bypasses the in-flight write onto both read ports and flags reads
// that match a load still sitting in the buffer.
//   clk, rst                 : clock, synchronous active-high reset
//   alu_valid/ready/rd/data  : ALU result handshake
//   mem_valid/ready/rd/data  : load return handshake (into the buffer)
//   rg_wrt_en/dest/data      : registered register-file write
//   rd_addr1/2, rdata_in1/2  : decode read indices and raw register-file data
//   fwd_data1/2              : read data with the pending write bypassed in
//   load_hazard              : a read index matches a buffered load destination
module rf_writeback_arbiter
    import rv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_dest,
    output logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rdata_in1,
    input  logic [DATA_W-1:0] rdata_in2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic              load_hazard
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    wb_req_t                   fifo_head;
    wb_req_t                   push_req;
    wb_req_t                   sel_req;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      alu_sel;
    logic                      sel_valid;
    logic [FIFO_DEPTH-1:0]     ent_valid;
    reg_addr_t [FIFO_DEPTH-1:0] ent_rd;

    logic [SW-1:0]     starve_q, starve_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    assign push_req.rd   = mem_rd;
    assign push_req.data = mem_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_req  (push_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    always_comb begin
        // Buffer space comes from the registered count only; a pop in the
        // same cycle does not free a slot for a push.
        mem_ready = !rst && !fifo_full;
        alu_ready = !rst && !(!fifo_empty && (starve_q == STARVE_LIM));
        alu_sel   = alu_valid && alu_ready;
        fifo_pop  = !rst && !alu_sel && !fifo_empty;
        fifo_push = mem_valid && mem_ready;
        sel_valid = alu_sel || fifo_pop;

        sel_req = fifo_head;
        if (alu_sel) begin
            sel_req.rd   = alu_rd;
            sel_req.data = alu_data;
        end

        // Counts ALU wins only while a load is waiting.
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (alu_sel && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end

        // x0 writes are consumed but never reach the register file.
        wr_en_d   = sel_valid && (sel_req.rd != '0);
        wr_dest_d = sel_valid ? sel_req.rd   : wr_dest_q;
        wr_data_d = sel_valid ? sel_req.data : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rg_wrt_en   = wr_en_q;
    assign rg_wrt_dest = wr_dest_q;
    assign rg_wrt_data = wr_data_q;

    always_comb begin
        fwd_data1 = rdata_in1;
        fwd_data2 = rdata_in2;
        if (wr_en_q && (wr_dest_q == rd_addr1) && (rd_addr1 != '0)) begin
            fwd_data1 = wr_data_q;
        end
        if (wr_en_q && (wr_dest_q == rd_addr2) && (rd_addr2 != '0)) begin
            fwd_data2 = wr_data_q;
        end
    end

    always_comb begin
        load_hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] != '0) &&
                ((ent_rd[i] == rd_addr1) || (ent_rd[i] == rd_addr2))) begin
                load_hazard = 1'b1;
            end
        end
    end

endmodule
